// File: rtl/chirp_pkg.sv
// Shared constants, state encoding and chirp phase-increment arithmetic
// for the chirp symbol sequencer.
package chirp_pkg;

  localparam int SF_W    = 4;
  localparam int IDX_W   = 12;
  localparam int PHASE_W = 16;
  localparam int NSYM_W  = 8;

  localparam logic [SF_W-1:0] SF_MIN = 4'd7;
  localparam logic [SF_W-1:0] SF_MAX = 4'd12;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  // incr(k) = k*2^(P-sf) - 2^(P-1), wrapping in P bits
  function automatic logic [PHASE_W-1:0] phase_incr(
    input logic [IDX_W-1:0] k,
    input logic [SF_W-1:0]  sf
  );
    logic [PHASE_W-1:0] k_ext;
    logic [PHASE_W-1:0] half;
    logic [7:0]         shamt;
    k_ext = PHASE_W'(k);
    half  = {1'b1, {(PHASE_W-1){1'b0}}};
    shamt = 8'(PHASE_W) - 8'(sf);
    return (k_ext << shamt) - half;
  endfunction

endpackage

// File: rtl/chirp_phase_accumulator.sv
// Phase-continuous chirp accumulator: cleared at frame start, advanced by
// incr(idx) on every accepted sample tick.
module chirp_phase_accumulator
  import chirp_pkg::*;
#(
  parameter int SF_BITWIDTH    = SF_W,
  parameter int IDX_BITWIDTH   = IDX_W,
  parameter int PHASE_BITWIDTH = PHASE_W
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_clr,
  input  logic                      i_en,
  input  logic [IDX_BITWIDTH-1:0]   i_idx,
  input  logic [SF_BITWIDTH-1:0]    i_sf,
  output logic [PHASE_BITWIDTH-1:0] o_acc
);

  logic [PHASE_BITWIDTH-1:0] acc_r;
  logic [PHASE_BITWIDTH-1:0] incr_s;

  assign incr_s = PHASE_BITWIDTH'(phase_incr(IDX_W'(i_idx), SF_W'(i_sf)));
  assign o_acc  = acc_r;

  // Accumulator register; clear wins over enable
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc_r <= {PHASE_BITWIDTH{1'b0}};
    end else if (i_clr) begin
      acc_r <= {PHASE_BITWIDTH{1'b0}};
    end else if (i_en) begin
      acc_r <= acc_r + incr_s;
    end else begin
      acc_r <= acc_r;
    end
  end

endmodule

// File: rtl/chirp_symbol_sequencer.sv
// Chirp symbol sequencer: requests sample ticks, walks the up-chirp chip
// index per symbol, repeats the symbol per frame and flags completion.
module chirp_symbol_sequencer
  import chirp_pkg::*;
#(
  parameter int SF_BITWIDTH    = SF_W,
  parameter int IDX_BITWIDTH   = IDX_W,
  parameter int PHASE_BITWIDTH = PHASE_W,
  parameter int NSYM_BITWIDTH  = NSYM_W
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start_n,
  input  logic [SF_BITWIDTH-1:0]    i_sf,
  input  logic [IDX_BITWIDTH-1:0]   i_symbol,
  input  logic [NSYM_BITWIDTH-1:0]  i_num_symbols,
  input  logic                      i_sample_tick_n,
  output logic                      o_tick_run,
  output logic [IDX_BITWIDTH-1:0]   o_chip_idx,
  output logic [PHASE_BITWIDTH-1:0] o_phase,
  output logic                      o_sample_valid,
  output logic                      o_symbol_done_n,
  output logic                      o_frame_done,
  output logic                      o_cfg_err,
  output logic                      o_busy
);

  logic [1:0]                state_r, state_nxt_s;
  logic [SF_BITWIDTH-1:0]    sf_r;
  logic [IDX_BITWIDTH-1:0]   sym_r, idx_r, chip_cnt_r;
  logic [NSYM_BITWIDTH-1:0]  nsym_r, sym_cnt_r;
  logic [IDX_BITWIDTH-1:0]   mask_s, start_mask_s;
  logic [PHASE_BITWIDTH-1:0] acc_s;
  logic                      tick_s, start_s, cfg_ok_s, accept_s;
  logic                      last_chip_s, last_sym_s;

  logic                      tick_run_r, valid_r, sym_done_n_r;
  logic                      frame_done_r, cfg_err_r, busy_r;
  logic [IDX_BITWIDTH-1:0]   chip_idx_r;
  logic [PHASE_BITWIDTH-1:0] phase_r;

  assign tick_s       = (state_r == ST_RUN) && !i_sample_tick_n;
  assign start_s      = (state_r == ST_IDLE) && !i_start_n;
  assign cfg_ok_s     = (i_sf >= SF_MIN) && (i_sf <= SF_MAX)
                        && (i_num_symbols != {NSYM_BITWIDTH{1'b0}});
  assign accept_s     = start_s && cfg_ok_s;
  assign mask_s       = (IDX_BITWIDTH'(1'b1) << sf_r) - IDX_BITWIDTH'(1'b1);
  assign start_mask_s = (IDX_BITWIDTH'(1'b1) << i_sf) - IDX_BITWIDTH'(1'b1);
  assign last_chip_s  = (chip_cnt_r == mask_s);
  assign last_sym_s   = (sym_cnt_r == (nsym_r - NSYM_BITWIDTH'(1'b1)));

  chirp_phase_accumulator #(
    .SF_BITWIDTH    (SF_BITWIDTH),
    .IDX_BITWIDTH   (IDX_BITWIDTH),
    .PHASE_BITWIDTH (PHASE_BITWIDTH)
  ) u_acc (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (accept_s),
    .i_en  (tick_s),
    .i_idx (idx_r),
    .i_sf  (sf_r),
    .o_acc (acc_s)
  );

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nxt_s = ST_RUN;
        else          state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (tick_s && last_chip_s && last_sym_s) state_nxt_s = ST_DONE;
        else                                     state_nxt_s = ST_RUN;
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State and registered status/handshake outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r      <= ST_IDLE;
      tick_run_r   <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      cfg_err_r    <= 1'b0;
      valid_r      <= 1'b0;
      sym_done_n_r <= 1'b1;
    end else begin
      state_r      <= state_nxt_s;
      tick_run_r   <= (state_nxt_s == ST_RUN);
      busy_r       <= (state_nxt_s != ST_IDLE);
      frame_done_r <= (state_r == ST_DONE);
      cfg_err_r    <= start_s && !cfg_ok_s;
      valid_r      <= tick_s;
      sym_done_n_r <= !(tick_s && last_chip_s);
    end
  end

  // Frame configuration, chip/symbol counters and sample outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sf_r       <= {SF_BITWIDTH{1'b0}};
      sym_r      <= {IDX_BITWIDTH{1'b0}};
      nsym_r     <= {NSYM_BITWIDTH{1'b0}};
      idx_r      <= {IDX_BITWIDTH{1'b0}};
      chip_cnt_r <= {IDX_BITWIDTH{1'b0}};
      sym_cnt_r  <= {NSYM_BITWIDTH{1'b0}};
      chip_idx_r <= {IDX_BITWIDTH{1'b0}};
      phase_r    <= {PHASE_BITWIDTH{1'b0}};
    end else if (accept_s) begin
      sf_r       <= i_sf;
      sym_r      <= i_symbol & start_mask_s;
      nsym_r     <= i_num_symbols;
      idx_r      <= i_symbol & start_mask_s;
      chip_cnt_r <= {IDX_BITWIDTH{1'b0}};
      sym_cnt_r  <= {NSYM_BITWIDTH{1'b0}};
    end else if (tick_s) begin
      chip_idx_r <= idx_r;
      phase_r    <= acc_s;
      if (last_chip_s) begin
        // Next symbol restarts at the symbol value; the phase keeps running
        chip_cnt_r <= {IDX_BITWIDTH{1'b0}};
        idx_r      <= sym_r;
        sym_cnt_r  <= last_sym_s ? sym_cnt_r : (sym_cnt_r + NSYM_BITWIDTH'(1'b1));
      end else begin
        chip_cnt_r <= chip_cnt_r + IDX_BITWIDTH'(1'b1);
        idx_r      <= (idx_r + IDX_BITWIDTH'(1'b1)) & mask_s;
      end
    end
  end

  assign o_tick_run      = tick_run_r;
  assign o_chip_idx      = chip_idx_r;
  assign o_phase         = phase_r;
  assign o_sample_valid  = valid_r;
  assign o_symbol_done_n = sym_done_n_r;
  assign o_frame_done    = frame_done_r;
  assign o_cfg_err       = cfg_err_r;
  assign o_busy          = busy_r;

endmodule

// File: doc/chirp_symbol_sequencer.md
Name: chirp_symbol_sequencer

Overview:
Consumer side of the sample-tick interface. It requests ticks from the bandwidth tick source through a run level. On each active-low sample tick it advances a LoRa-style up-chirp: chip index is (symbol + n) mod 2^SF, and the phase accumulator is continuous across the frame. It repeats the configured symbol a set number of times per frame, feeds the downstream NCO/DAC path, and reports symbol and frame completion.

Parameters:
SF_BITWIDTH, 4, width of spreading-factor input (legal SF 7..12)
IDX_BITWIDTH, 12, chip index / symbol width (2^12 = SF12 chips)
PHASE_BITWIDTH, 16, phase accumulator width P
NSYM_BITWIDTH, 8, symbol-count width

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous, active-high reset
i_start_n  in  1  active-low 1-cycle frame request
i_sf  in  SF_BITWIDTH  spreading factor, sampled at start
i_symbol  in  IDX_BITWIDTH  symbol value, sampled at start, masked to SF bits
i_num_symbols  in  NSYM_BITWIDTH  symbols per frame, sampled at start
i_sample_tick_n  in  1  active-low 1-cycle sample tick from the tick source
o_tick_run  out  1  level; high requests ticks from the tick source
o_chip_idx  out  IDX_BITWIDTH  chip index of current sample
o_phase  out  PHASE_BITWIDTH  phase of current sample
o_sample_valid  out  1  1-cycle pulse qualifying o_chip_idx/o_phase
o_symbol_done_n  out  1  active-low 1-cycle pulse on last chip of each symbol
o_frame_done  out  1  1-cycle pulse at end of frame
o_cfg_err  out  1  1-cycle pulse on rejected start
o_busy  out  1  high in RUN and DONE

Behaviour:
- Reset (async, any state): state IDLE, all counters and accumulator 0, o_tick_run=0, o_sample_valid=0, o_symbol_done_n=1, o_frame_done=0, o_cfg_err=0, o_busy=0, o_chip_idx=0, o_phase=0.
- States: IDLE, RUN, DONE.
- IDLE, i_start_n low:
  - If i_sf outside 7..12 or i_num_symbols==0: pulse o_cfg_err next cycle and stay IDLE.
  - Otherwise latch sf, sym = i_symbol & (2^sf-1), nsym. Set idx=sym, chip_cnt=0, sym_cnt=0, acc=0. Go RUN with o_tick_run=1 from the next cycle.
- Ticks in IDLE/DONE are ignored. Start requests in RUN/DONE are ignored (no error).
- RUN, tick sampled low at cycle t. Outputs are registered and appear at t+1:
  - o_chip_idx=idx, o_phase=acc, o_sample_valid=1.
  - acc <= acc + incr(idx) mod 2^P, where incr(k) = k*2^(P-sf) - 2^(P-1), computed in P bits with wrap.
  - idx <= (idx+1) mod 2^sf; chip_cnt++.
- Last chip of a symbol (tick with chip_cnt == 2^sf-1): o_symbol_done_n=0 alongside that sample's valid; chip_cnt <= 0; idx <= sym; acc keeps running (phase-continuous).
  - If sym_cnt == nsym-1: go DONE. Otherwise sym_cnt++.
- DONE (one cycle): o_tick_run=0, o_frame_done=1, then IDLE. o_tick_run drops on the cycle after the final tick.
- Latency: tick to o_sample_valid is exactly 1 cycle. Back-to-back ticks on consecutive cycles must each produce a sample.
- Config inputs are don't-care outside the start cycle.

Decomposition:
- Package chirp_pkg: state encoding, SF_MIN=7, SF_MAX=12, default widths, function for incr(k, sf).
- One sub-module, chirp_phase_accumulator: registered P-bit accumulator with clear/enable inputs and the incr arithmetic. The sequencer keeps the FSM and counters.

Test Plan:
- SF7, symbol 0, nsym 1, tick every 80 cycles -> 128 valid pulses with idx 0..127; phases 0, 32768, 512, ...; one o_symbol_done_n on idx 127; o_frame_done 1 cycle after; o_tick_run low.
- SF7, symbol 100 -> idx 100..127 then 0..99; wrap at sample 28; symbol_done on the sample with idx 99.
- SF8, symbol 5, nsym 3 -> 768 valids, 3 symbol_done pulses, second symbol restarts at idx 5, phase continuous (no reset to 0), single frame_done.
- Start with sf=6, then sf=13, then nsym=0 -> o_cfg_err pulse each time, o_busy and o_tick_run stay 0, ticks produce no valids.
- Start pulse mid-RUN, plus ticks on consecutive cycles -> start ignored; every tick yields a valid exactly 1 cycle later.
- i_rst asserted asynchronously at chip 50 of SF9 -> outputs take reset values immediately without a clock edge; following ticks ignored until a new start.
